// File: rtl/mem_responder.sv
// mem_responder: target end of the memory-stage load/store interface.
//
// Accepts one request at a time (valid/ready), waits LATENCY cycles, then
// answers with one beat (store ack or single-word load) or a BURST_LEN-beat
// line refill (burst load). Backing store is a word-addressed internal RAM.
//
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   req_valid     request present            req_ready   can accept (IDLE)
//   req_we        1 = store, 0 = load        req_burst   line refill (loads)
//   req_addr      byte address               req_wdata   store data
//   resp_valid    response beat present      resp_ready  requester takes beat
//   resp_rdata    load data (0 for stores)   resp_last   final beat
//   busy          request in flight
module mem_responder #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int LATENCY        = 3,
  parameter int BURST_LEN      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic                     req_burst,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_last,
  output logic                     busy
);

  localparam int DEPTH  = 2 ** MEM_ADDR_WIDTH;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [MEM_ADDR_WIDTH-1:0] LINE_MASK = MEM_ADDR_WIDTH'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  // WAIT lasts LATENCY cycles: counter runs LATENCY-1 down to 0.
  localparam logic [LAT_W-1:0]          LAT_INIT  = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0]     mem_q [0:DEPTH-1];

  state_t                    state_q;
  logic                      we_q;
  logic                      burst_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [LAT_W-1:0]          lat_q;
  logic [BEAT_W-1:0]         beat_q;
  logic                      resp_valid_q;
  logic                      resp_last_q;
  logic [DATA_WIDTH-1:0]     resp_rdata_q;

  logic                      accept_s;
  logic [MEM_ADDR_WIDTH-1:0] word_idx_s;
  logic [MEM_ADDR_WIDTH-1:0] base_d;
  logic [BEAT_W-1:0]         beat_d;
  logic [MEM_ADDR_WIDTH-1:0] next_addr_s;
  logic                      unused_s;

  // Request decode: word index, line-aligned base, next-beat address.
  always_comb begin
    accept_s   = req_valid && (state_q == S_IDLE);
    word_idx_s = req_addr[MEM_ADDR_WIDTH+1:2];
    // Burst flag only matters for loads; stores always address one word.
    if (req_burst && !req_we) begin
      base_d = word_idx_s & ~LINE_MASK;
    end else begin
      base_d = word_idx_s;
    end
    beat_d      = beat_q + BEAT_W'(1);
    // Aligned base means this never wraps inside a line.
    next_addr_s = base_q + MEM_ADDR_WIDTH'(beat_d);
  end

  // Address bits outside the word index alias and are deliberately dropped.
  assign unused_s = ^{req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+2], req_addr[1:0]};

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_last  = resp_last_q;
  assign resp_rdata = resp_rdata_q;

  // Backing RAM: stores commit on the acceptance edge; reset leaves it alone.
  always_ff @(posedge clk) begin
    if (accept_s && req_we) begin
      mem_q[word_idx_s] <= req_wdata;
    end
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      burst_q      <= 1'b0;
      base_q       <= '0;
      lat_q        <= '0;
      beat_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            we_q    <= req_we;
            burst_q <= req_burst && !req_we;
            base_q  <= base_d;
            lat_q   <= LAT_INIT;
            beat_q  <= '0;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (lat_q == '0) begin
            state_q      <= S_RESP;
            beat_q       <= '0;
            resp_valid_q <= 1'b1;
            resp_last_q  <= !burst_q;
            resp_rdata_q <= we_q ? '0 : mem_q[base_q];
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            if (resp_last_q) begin
              // Drop valid for one cycle before the next acceptance.
              state_q      <= S_IDLE;
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              // Only bursts reach here, and bursts are always loads.
              beat_q       <= beat_d;
              resp_rdata_q <= mem_q[next_addr_s];
              resp_last_q  <= (beat_d == LAST_BEAT);
            end
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_last_q  <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int LAT   = 3;
  localparam int BL    = 8;
  localparam int MAW   = 8;
  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_burst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_last;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_ADDR_WIDTH(MAW),
    .LATENCY       (LAT),
    .BURST_LEN     (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_last (resp_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction is: accepted at edge E, first beat visible from cycle E+LAT,
  // beats consumed one per resp_ready cycle, idle again after the last one.
  int          cyc = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_beats [BL];
  bit          m_act = 1'b0;
  int          m_start = 0;
  int          m_n = 0;
  int          m_idx = 0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

  function automatic int word_idx(input logic [31:0] a);
    return int'(a[MAW+1:2]);
  endfunction

  function automatic int line_base(input logic [31:0] a, input logic burst, input logic we);
    int w;
    w = word_idx(a);
    if (burst && !we) return w - (w % BL);
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_idx <= 0;
    end else begin
      if (m_act) begin
        if (cyc >= m_start && resp_ready) begin
          m_idx <= m_idx + 1;
          if (m_idx + 1 == m_n) m_act <= 1'b0;
        end
      end else if (req_valid) begin
        m_act   <= 1'b1;
        m_idx   <= 0;
        m_start <= cyc + 1 + LAT;
        if (req_we) begin
          m_mem[word_idx(req_addr)] <= req_wdata;
          m_n        <= 1;
          m_beats[0] <= 32'h0;
        end else begin
          m_n <= req_burst ? BL : 1;
          for (int i = 0; i < BL; i++)
            m_beats[i] <= m_mem[(line_base(req_addr, req_burst, req_we) + i) % DEPTH];
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", {31'h0, req_ready}, {31'h0, !m_act});
      chk("busy", {31'h0, busy}, {31'h0, m_act});
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, (m_act && cyc >= m_start)});
      if (m_act && cyc >= m_start) begin
        chk("resp_rdata", resp_rdata, m_beats[m_idx]);
        chk("resp_last", {31'h0, resp_last}, {31'h0, (m_idx == m_n - 1)});
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] cap_data[$];
  bit          cap_last[$];
  int          cap_cyc[$];
  int          first_valid;
  int          acc_edge;

  // Present a request (called just after a rising edge); returns just after
  // the accepting edge.
  task automatic send(input logic we, input logic burst, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold);
    bit seen;
    int g;
    seen = 1'b0;
    g = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    while (!seen && g < 400) begin
      @(negedge clk);
      seen = req_ready;
      acc_edge = cyc + 1;
      @(posedge clk);
      #1;
      g++;
    end
    if (!seen) chk("accept_timeout", 32'h0, 32'h1);
    if (!hold) req_valid = 1'b0;
  endtask

  // Collect beats until resp_last; optional random or targeted backpressure.
  task automatic wait_done(input int bp_beat, input int bp_len, input logic [31:0] hold_val,
                           input bit rnd);
    int  guard;
    int  left;
    bit  done;
    cap_data.delete();
    cap_last.delete();
    cap_cyc.delete();
    first_valid = -1;
    left  = bp_len;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 400) begin
      if (rnd) resp_ready = ($urandom_range(0, 3) != 0);
      else     resp_ready = !(cap_data.size() == bp_beat && left > 0);
      @(negedge clk);
      if (resp_valid && first_valid < 0) first_valid = cyc;
      if (!rnd && !resp_ready && resp_valid && cap_data.size() == bp_beat && left > 0) begin
        chk("bp_hold_rdata", resp_rdata, hold_val);
        left--;
      end
      if (resp_valid && resp_ready) begin
        cap_data.push_back(resp_rdata);
        cap_last.push_back(resp_last);
        cap_cyc.push_back(cyc);
        if (resp_last) done = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    resp_ready = 1'b1;
    if (!done) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int hs_edge;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    #2;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_last", {31'h0, resp_last}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Bring RAM to a known all-zero state.
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
      wait_done(-1, 0, 32'h0, 1'b0);
    end

    // Store timing and ack shape.
    send(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    wait_done(-1, 0, 32'h0, 1'b0);
    chk("store_latency", 32'(first_valid - acc_edge), 32'd3);
    chk("store_beats", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() >= 1) begin
      chk("store_rdata", cap_data[0], 32'h0);
      chk("store_last", {31'h0, cap_last[0]}, 32'h1);
    end
    send(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    wait_done(-1, 0, 32'h0, 1'b0);
    chk("load_beats", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() >= 1) chk("load_rdata", cap_data[0], 32'hDEAD_BEEF);

    // Burst refill: preload line 0x20..0x3C with 0..7.
    for (int i = 0; i < BL; i++) begin
      send(1'b1, 1'b0, 32'(32'h20 + i * 4), 32'(i), 1'b0);
      wait_done(-1, 0, 32'h0, 1'b0);
    end
    send(1'b0, 1'b1, 32'h0000_002C, 32'h0, 1'b0);
    wait_done(-1, 0, 32'h0, 1'b0);
    chk("burst_beats", 32'(cap_data.size()), 32'd8);
    if (cap_data.size() == BL) begin
      for (int i = 0; i < BL; i++) begin
        chk("burst_rdata", cap_data[i], 32'(i));
        chk("burst_last", {31'h0, cap_last[i]}, {31'h0, (i == BL - 1)});
        if (i > 0) chk("burst_consec", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
      end
    end

    // Burst with 3 cycles of backpressure on beat 2.
    send(1'b0, 1'b1, 32'h0000_002C, 32'h0, 1'b0);
    wait_done(2, 3, 32'd2, 1'b0);
    chk("bp_beats", 32'(cap_data.size()), 32'd8);
    if (cap_data.size() == BL) begin
      chk("bp_beat2", cap_data[2], 32'd2);
      chk("bp_resume3", cap_data[3], 32'd3);
      chk("bp_gap", 32'(cap_cyc[2] - cap_cyc[1]), 32'd4);
    end

    // Aliasing and store-with-burst.
    send(1'b1, 1'b1, 32'h0000_0403, 32'h0000_1234, 1'b0);
    wait_done(-1, 0, 32'h0, 1'b0);
    chk("store_burst_beats", 32'(cap_data.size()), 32'd1);
    send(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    wait_done(-1, 0, 32'h0, 1'b0);
    if (cap_data.size() >= 1) chk("alias_rdata", cap_data[0], 32'h0000_1234);

    // Back-to-back requests with req_valid held high throughout.
    send(1'b0, 1'b1, 32'h0000_0020, 32'h0, 1'b1);
    req_we = 1'b0; req_burst = 1'b0; req_addr = 32'h0000_0010;
    wait_done(-1, 0, 32'h0, 1'b0);
    hs_edge = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size() - 1] + 1 : 0;
    send(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk("b2b_accept_gap", 32'(acc_edge - hs_edge), 32'd1);
    wait_done(-1, 0, 32'h0, 1'b0);
    if (cap_data.size() >= 1) chk("b2b_rdata", cap_data[0], 32'hDEAD_BEEF);

    // Reset in WAIT after a store: store survives.
    send(1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstw_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstw_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
    wait_done(-1, 0, 32'h0, 1'b0);
    if (cap_data.size() >= 1) chk("rstw_reload", cap_data[0], 32'hCAFE_F00D);

    // Reset while a response is stalled in RESP.
    resp_ready = 1'b0;
    send(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    g = 0;
    while (!resp_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("rstr_valid_seen", {31'h0, resp_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstr_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstr_resp_last", {31'h0, resp_last}, 32'h0);
    chk("rstr_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;

    // Randomised traffic; checked every cycle by the model comparison.
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
      wait_done(-1, 0, 32'h0, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
